// File: rtl/fpu_ss_lsu.sv
// FPU subsystem load/store unit: single-outstanding memory port with lane
// alignment of store data / byte enables and NaN-boxed load extraction.
module fpu_ss_lsu #(
    parameter int unsigned FLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [FLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_err_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [FLEN-1:0]   rsp_data_o,
    output logic [4:0]        rsp_rd_o,
    output logic              rsp_we_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e          r_state;
    logic            r_we;
    logic [1:0]      r_size;
    logic [1:0]      r_off;
    logic [4:0]      r_rd;

    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic            w_bad;
    logic [31:0]     w_shift;
    logic [FLEN-1:0] w_load;
    logic            w_unused_wdata;

    // Only the low word of the FP operand is ever stored.
    assign w_unused_wdata = &{1'b0, req_wdata_i};

    assign w_bad = (req_size_i == SZ_D)
                 || ((req_size_i == SZ_H) && req_addr_i[0])
                 || ((req_size_i == SZ_W) && (req_addr_i[1:0] != 2'b00));

    // Lane placement of byte enables and replicated store data.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (req_size_i)
            SZ_B: begin
                w_be    = 4'b0001 << req_addr_i[1:0];
                w_wdata = {4{req_wdata_i[7:0]}};
            end
            SZ_H: begin
                w_be    = 4'b0011 << req_addr_i[1:0];
                w_wdata = {2{req_wdata_i[15:0]}};
            end
            SZ_W: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata_i[31:0];
            end
            default: ;
        endcase
    end

    assign w_shift = mem_rdata_i >> {r_off, 3'b000};

    // Extract the addressed lane and NaN-box everything above it.
    always_comb begin
        w_load = '1;
        case (r_size)
            SZ_B:    w_load[7:0]  = w_shift[7:0];
            SZ_H:    w_load[15:0] = w_shift[15:0];
            default: w_load[31:0] = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_rd        <= 5'd0;
            req_ready_o <= 1'b1;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= 32'h0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_rd_o    <= 5'd0;
            rsp_we_o    <= 1'b0;
            rsp_err_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we        <= req_we_i;
                        r_size      <= req_size_i;
                        r_off       <= req_addr_i[1:0];
                        r_rd        <= req_rd_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (w_bad) begin
                            r_state     <= S_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_we_o    <= 1'b0;
                            rsp_data_o  <= '0;
                            rsp_rd_o    <= req_rd_i;
                        end else begin
                            r_state     <= S_REQ;
                            mem_valid_o <= 1'b1;
                            mem_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            mem_we_o    <= req_we_i;
                            mem_be_o    <= w_be;
                            mem_wdata_o <= req_we_i ? w_wdata : 32'h0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        r_state     <= S_WAIT;
                        mem_valid_o <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_state     <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= mem_err_i;
                        rsp_we_o    <= !r_we && !mem_err_i;
                        rsp_data_o  <= (!r_we && !mem_err_i) ? w_load : '0;
                        rsp_rd_o    <= r_rd;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_we_o    <= 1'b0;
                        rsp_data_o  <= '0;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
